pipe_skid_reg: RTL
==================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter WIDTH, default 8: payload width in bits, legal range 1..256.
REQ-002 Parameter RESET_VAL, default 0: WIDTH-bit value loaded into both data registers on reset and flush.
REQ-003 Port clk  input  1: clock; all state updates on its rising edge.
REQ-004 Port rst  input  1: reset, asynchronous, active-high.
REQ-005 Port flush  input  1: synchronous pipeline clear, active-high.
REQ-006 Port in_valid  input  1: upstream payload valid.
REQ-007 Port in_ready  output  1: block can accept a payload this cycle; driven directly from a flop.
REQ-008 Port in_data  input  WIDTH: upstream payload.
REQ-009 Port out_valid  output  1: out_data holds a valid payload.
REQ-010 Port out_ready  input  1: downstream accepts a payload this cycle.
REQ-011 Port out_data  output  WIDTH: downstream payload; driven directly from a flop.
REQ-012 Port stall_cnt  output  32: output stall-cycle count; present only under REQ-030.

Function
REQ-013 Define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready.
REQ-014 Storage consists of a main register (out_valid, out_data) and a skid register (skid_valid, skid_data).
REQ-015 Drive in_ready = !skid_valid, so that no combinational path exists from out_ready to in_ready.
REQ-016 Occupancy states:
- EMPTY: neither register valid.
- ONE: main register valid only.
- TWO: both registers valid.
REQ-017 EMPTY: on in_fire, load main and go to ONE; otherwise hold.
REQ-018 ONE transitions:
- out_fire and in_fire: load main from in_data, stay in ONE.
- out_fire only: go to EMPTY.
- in_fire without out_fire: load skid, go to TWO.
- Neither: hold.
REQ-019 TWO: in_ready = 0; on out_fire, copy skid to main, clear skid_valid and go to ONE; otherwise hold.
REQ-020 Latency is 1 cycle from in_fire to out_valid when starting from EMPTY or ONE-with-out_fire; sustained throughput is 1 payload/cycle.
REQ-021 Ordering: payloads leave in exact acceptance order; none is duplicated or dropped except by flush.
REQ-022 Flush has priority over all handshakes. On the next edge, out_valid and skid_valid go to 0 and both data registers take RESET_VAL. An in_fire in the flush cycle is discarded, and state goes to EMPTY.
REQ-023 out_data and out_valid remain stable while out_valid & !out_ready, unless flush or rst occurs.
REQ-024 A data register loads only when its valid is being set or on a skid-to-main copy; otherwise it holds its value.

Reset
REQ-025 While rst is high: out_valid = 0, skid_valid = 0, in_ready = 1, out_data = RESET_VAL, skid_data = RESET_VAL, and stall_cnt = 0, independent of clk.
REQ-026 Reset asserted mid-transfer aborts all held payloads; after release the block is in EMPTY.
REQ-027 After rst deasserts, the first edge may accept a payload.

Configuration
REQ-028 Macro PIPE_SKID_REG_STALL_CNT_EN controls the stall counter.
REQ-029 Without the macro, port stall_cnt and its logic are absent.
REQ-030 With the macro:
- stall_cnt increments each cycle with out_valid & !out_ready.
- It saturates at 32'hFFFF_FFFF.
- It is cleared only by rst, not by flush.

Structure
REQ-031 Shared package pipe_pkg holds:
- Occupancy enum (EMPTY, ONE, TWO).
- Constant PIPE_DEF_WIDTH = 8.
- Constant STALL_CNT_W = 32.
REQ-032 Each data register is an instance of sub-module flopenrc: a WIDTH-parameterised flop with async rst, enable, synchronous clear and reset value.

Verification
REQ-033 Streaming: after reset, send 0x11, 0x22, 0x33 on consecutive cycles with out_ready = 1. Required: out_data shows 0x11, 0x22, 0x33 one cycle later; in_ready stays 1 throughout.
REQ-034 Skid fill:
- Stimulus: out_ready = 0, send 0xA5 then 0x5A.
- Required: state reaches TWO and in_ready = 0.
- Then: raise out_ready for 2 cycles.
- Required: output is 0xA5 then 0x5A; in_ready returns to 1 after the first out_fire.
REQ-035 Flush in TWO with in_valid = 1 and in_data = 0x77: the next cycle shows out_valid = 0, in_ready = 1, out_data = RESET_VAL, and 0x77 never appears.
REQ-036 Async reset mid-cycle while in ONE: out_valid drops to 0 before the next clk edge; stall_cnt reads 0.
REQ-037 Random valid/ready, 10k cycles, WIDTH = 32: the scoreboard shows in-order, lossless output, and out_data is stable during stalls.
REQ-038 With PIPE_SKID_REG_STALL_CNT_EN: hold out_valid = 1, out_ready = 0 for 5 cycles, then flush. Required: stall_cnt = 5 and it remains 5 after the flush.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline skid register slice: occupancy encoding and widths.
package pipe_pkg;

  localparam int unsigned PIPE_DEF_WIDTH = 8;
  localparam int unsigned STALL_CNT_W    = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/flopenrc.sv
// Data flop with async reset, load enable and synchronous clear, both returning to RESET_VAL.
module flopenrc #(
  parameter int unsigned        WIDTH     = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      q <= RESET_VAL;
    else if (clr) q <= RESET_VAL;
    else if (en)  q <= d;
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid register: fully registered valid/ready handshake at one payload per cycle.
// Optional output stall counter enabled by macro PIPE_SKID_REG_STALL_CNT_EN.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = PIPE_DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data
`ifdef PIPE_SKID_REG_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  occ_e             state;
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic             in_fire;
  logic             out_fire;
  logic             main_en;
  logic             skid_en;
  logic [WIDTH-1:0] main_d;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Occupancy FSM; in_ready is kept as its own flop mirroring !skid_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
    end else if (flush) begin
      state      <= EMPTY;
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state     <= ONE;
            out_valid <= 1'b1;
          end
        end
        ONE: begin
          if (out_fire && !in_fire) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end else if (in_fire && !out_fire) begin
            state      <= TWO;
            skid_valid <= 1'b1;
            in_ready   <= 1'b0;
          end
        end
        TWO: begin
          if (out_fire) begin
            state      <= ONE;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
          end
        end
        default: begin
          state      <= EMPTY;
          out_valid  <= 1'b0;
          skid_valid <= 1'b0;
          in_ready   <= 1'b1;
        end
      endcase
    end
  end

  // Data registers load only when their valid is being set or on a skid-to-main copy.
  always_comb begin
    main_en = 1'b0;
    skid_en = 1'b0;
    main_d  = in_data;
    case (state)
      EMPTY:   main_en = in_fire;
      ONE: begin
        main_en = in_fire & out_fire;
        skid_en = in_fire & ~out_fire;
      end
      TWO: begin
        main_en = out_fire;
        main_d  = skid_valid ? skid_data : in_data;
      end
      default: main_en = 1'b0;
    endcase
  end

  flopenrc #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
    .clk (clk),
    .rst (rst),
    .en  (main_en),
    .clr (flush),
    .d   (main_d),
    .q   (out_data)
  );

  flopenrc #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
    .clk (clk),
    .rst (rst),
    .en  (skid_en),
    .clr (flush),
    .d   (in_data),
    .q   (skid_data)
  );

`ifdef PIPE_SKID_REG_STALL_CNT_EN
  // Saturating count of cycles the output is held back; flush does not clear it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end
`endif

endmodule
